axi_read_arbiter: RTL and testbench

Shares the single CPU AXI read channel (AR + R) between two cache requesters: port 0 is the data cache, port 1 the instruction cache. One burst is outstanding at a time. The arbiter grants one requester, forwards its AR beat to the bus, then routes every R beat back to it until `rlast`. Sits between the cache miss FSMs and the top-level AXI master port; write channels bypass it.

---
 rtl/axi_read_arbiter.sv | 109 ++++++++++
 tb/tb_axi_read_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
`timescale 1ns/1ps
// axi_read_arbiter: shares one AXI read channel (AR+R) between port 0 (dcache) and port 1 (icache), one burst outstanding.
// Ports: clk, rst (sync, active-low); s0_*/s1_* requester AR in / R out; m_* bus-side AR out / R in.
// Option: ARB_ROUND_ROBIN_EN selects round-robin between simultaneous requests; default is fixed priority to port 0.
module axi_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [7:0]            s0_arlen,
  input  logic [2:0]            s0_arsize,
  input  logic [1:0]            s0_arburst,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rlast,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [7:0]            s1_arlen,
  input  logic [2:0]            s1_arsize,
  input  logic [1:0]            s1_arburst,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rlast,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [3:0]            m_arid,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic [1:0]            m_arlock,
  output logic [3:0]            m_arcache,
  output logic [2:0]            m_arprot,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [3:0]            m_rid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_n;
  logic grant, grant_n, win, any_req, g_arvalid, in_addr, in_data, r_done, s0_data, s1_data;
  // only one burst is ever outstanding, so the returned id carries no routing information
  logic unused_rid;
  assign unused_rid = ^m_rid;
  assign any_req = s0_arvalid | s1_arvalid;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;
  assign win = (s0_arvalid & s1_arvalid) ? ~last_grant : s1_arvalid;
  always_ff @(posedge clk)
    if (!rst) last_grant <= 1'b1;
    else if (r_done) last_grant <= grant;
`else
  assign win = ~s0_arvalid;
`endif
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      grant <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
    end
  assign in_addr   = state == ADDR;
  assign in_data   = state == DATA;
  assign g_arvalid = grant ? s1_arvalid : s0_arvalid;
  assign r_done    = in_data & m_rvalid & m_rready & m_rlast;
  // a granted requester that drops arvalid before the handshake sends us back to IDLE
  always_comb begin
    state_n = state;
    grant_n = grant;
    state_n = state == IDLE ? (any_req ? ADDR : IDLE) :
              state == ADDR ? (!g_arvalid ? IDLE : m_arready ? DATA : ADDR) :
              (r_done ? IDLE : DATA);
    grant_n = (state == IDLE && any_req) ? win : grant;
  end
  assign m_arvalid  = in_addr & g_arvalid;
  assign m_arid     = in_addr ? {3'b000, grant} : 4'd0;
  assign m_araddr   = in_addr ? (grant ? s1_araddr : s0_araddr) : '0;
  assign m_arlen    = in_addr ? (grant ? s1_arlen : s0_arlen) : '0;
  assign m_arsize   = in_addr ? (grant ? s1_arsize : s0_arsize) : '0;
  assign m_arburst  = in_addr ? (grant ? s1_arburst : s0_arburst) : '0;
  assign m_arlock   = '0;
  assign m_arcache  = '0;
  assign m_arprot   = '0;
  assign s0_arready = in_addr & ~grant & m_arready;
  assign s1_arready = in_addr & grant & m_arready;
  assign s0_data    = in_data & ~grant;
  assign s1_data    = in_data & grant;
  assign m_rready   = in_data & (grant ? s1_rready : s0_rready);
  assign s0_rvalid  = s0_data & m_rvalid;
  assign s0_rlast   = s0_data & m_rlast;
  assign s0_rdata   = s0_data ? m_rdata : '0;
  assign s0_rresp   = s0_data ? m_rresp : '0;
  assign s1_rvalid  = s1_data & m_rvalid;
  assign s1_rlast   = s1_data & m_rlast;
  assign s1_rdata   = s1_data ? m_rdata : '0;
  assign s1_rresp   = s1_data ? m_rresp : '0;
endmodule

// File: tb/tb_axi_read_arbiter.sv
`timescale 1ns/1ps
// tb_axi_read_arbiter: directed scenarios for the two-port AXI read arbiter.
module tb_axi_read_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s0_araddr, s1_araddr, s0_rdata, s1_rdata, m_araddr, m_rdata;
  logic [7:0]  s0_arlen, s1_arlen, m_arlen;
  logic [2:0]  s0_arsize, s1_arsize, m_arsize, m_arprot;
  logic [1:0]  s0_arburst, s1_arburst, m_arburst, s0_rresp, s1_rresp, m_rresp, m_arlock;
  logic        s0_arvalid, s1_arvalid, s0_arready, s1_arready, s0_rlast, s1_rlast;
  logic        s0_rvalid, s1_rvalid, s0_rready, s1_rready;
  logic [3:0]  m_arid, m_arcache, m_rid;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  axi_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
    .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
    .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // serves one burst on the bus side and reports the observed grant and routing faults
  task automatic run_burst(input logic [7:0] len, output logic g, output int bad);
    bad = 0;
    g = 1'b0;
    #1;
    for (int n = 0; n < 8 && m_arvalid !== 1'b1; n++) begin
      @(posedge clk);
      #2;
    end
    if (m_arvalid !== 1'b1) begin
      bad = 1;
      return;
    end
    g = m_arid[0];
    m_arready = 1'b1;
    cyc;
    m_arready = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      m_rvalid = 1'b1;
      m_rdata = 32'hB000_0000 + 32'(i);
      m_rresp = 2'(i);
      m_rlast = (i == int'(len));
      #1;
      if (m_rready !== 1'b1) bad++;
      if (g ? (s1_rvalid !== 1'b1 || s1_rdata !== m_rdata || s1_rresp !== m_rresp || s1_rlast !== m_rlast || s0_rvalid !== 1'b0)
            : (s0_rvalid !== 1'b1 || s0_rdata !== m_rdata || s0_rresp !== m_rresp || s0_rlast !== m_rlast || s1_rvalid !== 1'b0)) bad++;
      cyc;
    end
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
    m_rdata = '0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    {s0_araddr, s1_araddr, m_rdata} = '0;
    {s0_arlen, s1_arlen} = '0;
    {s0_arsize, s1_arsize} = '0;
    {s0_arburst, s1_arburst, m_rresp} = '0;
    m_rid = 4'd0;
    {s0_rready, s1_rready, m_arready, m_rlast} = '0;
    s0_arvalid = 1'b1;
    s1_arvalid = 1'b1;
    m_rvalid = 1'b1;
    s0_araddr = 32'h1234_5678;
    s1_araddr = 32'h9abc_def0;
    for (int i = 0; i < 3; i++) begin
      cyc;
      #1;
      checks++;
      if ({m_arvalid, m_rready, s0_arready, s1_arready, s0_rvalid, s1_rvalid} !== 6'b0 ||
          m_arid !== 4'd0 || m_araddr !== 32'd0 || s0_rdata !== 32'd0 || s1_rdata !== 32'd0)
        begin errors++; $display("FAIL reset_outputs cycle %0d: arvalid=%b rready=%b arid=%h araddr=%h, required all 0", i, m_arvalid, m_rready, m_arid, m_araddr); end
    end
    checks++;
    if (m_arlock !== 2'd0 || m_arcache !== 4'd0 || m_arprot !== 3'd0)
      begin errors++; $display("FAIL reset_consts: lock=%h cache=%h prot=%h, required 0", m_arlock, m_arcache, m_arprot); end
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b0;
    m_rvalid = 1'b0;
    rst = 1'b1;
    cyc;
  endtask

  task automatic test_single;
    int bad = 0;
    s1_araddr = 32'h1fc0_0040; s1_arlen = 8'd15; s1_arsize = 3'd2; s1_arburst = 2'd1;
    s1_arvalid = 1'b1; s1_rready = 1'b1; s0_rready = 1'b1;
    #1;
    checks++;
    if (m_arvalid !== 1'b0) begin errors++; $display("FAIL single_bubble: m_arvalid=%b required 0", m_arvalid); end
    cyc;
    #1;
    checks++;
    if (m_arvalid !== 1'b1 || m_arid !== 4'd1 || m_araddr !== 32'h1fc0_0040 || m_arlen !== 8'd15 ||
        m_arsize !== 3'd2 || m_arburst !== 2'd1 || s1_arready !== 1'b0)
      begin errors++; $display("FAIL single_ar: arvalid=%b arid=%h araddr=%h arlen=%0d arready=%b, required 1/1/1fc00040/15/0", m_arvalid, m_arid, m_araddr, m_arlen, s1_arready); end
    cyc;
    m_arready = 1'b1;
    #1;
    checks++;
    if (s1_arready !== 1'b1 || s0_arready !== 1'b0 || m_arvalid !== 1'b1)
      begin errors++; $display("FAIL single_arready: s1=%b s0=%b m_arvalid=%b, required 1/0/1", s1_arready, s0_arready, m_arvalid); end
    cyc;
    s1_arvalid = 1'b0;
    m_arready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_rvalid = 1'b1;
      m_rdata = 32'h0000_1000 + 32'(i);
      m_rlast = (i == 15);
      #1;
      if (s1_rvalid !== 1'b1 || s1_rdata !== 32'h0000_1000 + 32'(i) || s1_rlast !== (i == 15) ||
          s0_rvalid !== 1'b0 || m_rready !== 1'b1 || m_arvalid !== 1'b0) bad++;
      cyc;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL single_beats: %0d bad beats, required 0", bad); end
    m_rlast = 1'b0;
    #1;
    checks++;
    if (m_rready !== 1'b0 || s1_rvalid !== 1'b0 || s0_rvalid !== 1'b0)
      begin errors++; $display("FAIL single_idle: m_rready=%b s1_rvalid=%b, required 0/0", m_rready, s1_rvalid); end
    m_rvalid = 1'b0;
    m_rdata = '0;
  endtask

  task automatic test_contention;
    logic g;
    int bad;
    logic [3:0] got = '0, exp;
`ifdef ARB_ROUND_ROBIN_EN
    exp = 4'b1010;
`else
    exp = 4'b0000;
`endif
    s0_araddr = 32'h0000_0100;
    s1_araddr = 32'h0000_0200;
    s0_arlen = 8'd1;
    s1_arlen = 8'd1;
    s0_arvalid = 1'b1;
    s1_arvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_burst(8'd1, g, bad);
      got[k] = g;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL contention_burst%0d: %0d bad beats, required 0", k, bad); end
    end
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b0;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL contention_grants: got %b (bit k = burst k), required %b", got, exp); end
    cyc;
  endtask

  task automatic test_stall;
    int k = 0, got = 0, stalls = 0, bad = 0, c = 0;
    logic acc, done = 1'b0;
    s0_araddr = 32'h0000_4000; s0_arlen = 8'd7; s0_arvalid = 1'b1;
    cyc;
    m_arready = 1'b1;
    cyc;
    m_arready = 1'b0;
    s0_arvalid = 1'b0;
    while (!done && c < 30) begin
      s0_rready = !(c >= 3 && c <= 5);
      m_rvalid = 1'b1;
      m_rdata = 32'hC000_0000 + 32'(k);
      m_rlast = (k == 7);
      #1;
      if (m_rready !== s0_rready) bad++;
      if (m_rready === 1'b0) stalls++;
      acc = m_rready;
      if (s0_rvalid && s0_rready) begin
        if (s0_rdata !== 32'hC000_0000 + 32'(got)) bad++;
        got++;
        done = s0_rlast;
      end
      cyc;
      if (acc) k++;
      c++;
    end
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
    s0_rready = 1'b1;
    checks++;
    if (got != 8 || !done) begin errors++; $display("FAIL stall_count: received %0d beats last=%b, required 8/1", got, done); end
    checks++;
    if (stalls != 3 || bad != 0) begin errors++; $display("FAIL stall_rready: stalls=%0d bad=%0d, required 3/0", stalls, bad); end
  endtask

  task automatic test_back_to_back;
    int bad = 0;
    s1_araddr = 32'h0000_8000; s1_arlen = 8'd3; s1_arvalid = 1'b1;
    cyc;
    m_arready = 1'b1;
    cyc;
    s1_arvalid = 1'b0;
    s0_araddr = 32'h0000_9000; s0_arlen = 8'd0; s0_arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_rvalid = 1'b1;
      m_rdata = 32'(i);
      m_rlast = (i == 3);
      #1;
      if (s0_arready !== 1'b0 || m_arvalid !== 1'b0 || s1_rvalid !== 1'b1) bad++;
      cyc;
    end
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
    #1;
    checks++;
    if (bad != 0 || s0_arready !== 1'b0 || m_arvalid !== 1'b0)
      begin errors++; $display("FAIL holdoff: bad=%0d s0_arready=%b m_arvalid=%b, required 0/0/0", bad, s0_arready, m_arvalid); end
    cyc;
    #1;
    checks++;
    if (m_arvalid !== 1'b1 || m_arid !== 4'd0 || m_araddr !== 32'h0000_9000 || s0_arready !== 1'b1)
      begin errors++; $display("FAIL b2b_grant: arvalid=%b arid=%h araddr=%h s0_arready=%b, required 1/0/00009000/1", m_arvalid, m_arid, m_araddr, s0_arready); end
    cyc;
    s0_arvalid = 1'b0;
    m_arready = 1'b0;
    m_rvalid = 1'b1;
    m_rlast = 1'b1;
    m_rdata = 32'h5a5a_5a5a;
    #1;
    checks++;
    if (s0_rvalid !== 1'b1 || s0_rdata !== 32'h5a5a_5a5a || s0_rlast !== 1'b1)
      begin errors++; $display("FAIL b2b_beat: rvalid=%b rdata=%h, required 1/5a5a5a5a", s0_rvalid, s0_rdata); end
    cyc;
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic g;
    int bad;
    s1_araddr = 32'h0000_a000; s1_arlen = 8'd15; s1_arvalid = 1'b1;
    cyc;
    m_arready = 1'b1;
    cyc;
    m_arready = 1'b0;
    s1_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      m_rvalid = 1'b1;
      m_rdata = 32'(i);
      if (i == 4) rst = 1'b0;
      cyc;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({m_arvalid, m_rready, s0_arready, s1_arready, s0_rvalid, s1_rvalid, s1_rlast} !== 7'b0 ||
        m_arid !== 4'd0 || m_araddr !== 32'd0 || s1_rdata !== 32'd0)
      begin errors++; $display("FAIL reset_mid: m_rready=%b s1_rvalid=%b s1_rdata=%h, required 0/0/0", m_rready, s1_rvalid, s1_rdata); end
    m_rvalid = 1'b0;
    s0_araddr = 32'h0000_b000; s0_arlen = 8'd2; s0_arvalid = 1'b1;
    run_burst(8'd2, g, bad);
    s0_arvalid = 1'b0;
    checks++;
    if (g !== 1'b0 || bad != 0) begin errors++; $display("FAIL reset_recover: grant=%b bad=%0d, required 0/0", g, bad); end
  endtask

  task automatic test_idle_spurious;
    int bad = 0;
    for (int i = 0; i < 2; i++) begin
      m_rvalid = 1'b1;
      m_rlast = 1'b1;
      #1;
      if (m_rready !== 1'b0 || s0_rvalid !== 1'b0 || s1_rvalid !== 1'b0) bad++;
      cyc;
    end
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_spurious: %0d cycles with beat accepted or routed, required 0", bad); end
  endtask

  task automatic test_withdraw;
    s0_araddr = 32'h0000_c000; s0_arvalid = 1'b1;
    cyc;
    s0_arvalid = 1'b0;
    #1;
    checks++;
    if (m_arvalid !== 1'b0) begin errors++; $display("FAIL withdraw_drop: m_arvalid=%b required 0", m_arvalid); end
    cyc;
    s1_araddr = 32'h0000_d000; s1_arvalid = 1'b1;
    cyc;
    #1;
    checks++;
    if (m_arvalid !== 1'b1 || m_arid !== 4'd1 || m_araddr !== 32'h0000_d000)
      begin errors++; $display("FAIL withdraw_regrant: arvalid=%b arid=%h araddr=%h, required 1/1/0000d000", m_arvalid, m_arid, m_araddr); end
    m_arready = 1'b1;
    cyc;
    m_arready = 1'b0;
    s1_arvalid = 1'b0;
    m_rvalid = 1'b1;
    m_rlast = 1'b1;
    cyc;
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_stall;
    test_back_to_back;
    test_reset_mid;
    test_idle_spurious;
    test_withdraw;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
